// File: rtl/fetch_pc_unit.sv
// Program-counter and fetch sequencer for the single-cycle core. Holds the fetch
// address, forwards the fetched word to the decoder while running, applies branch
// redirects, and freezes on the branch-to-self halt idiom while counting retirements.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hEAFF_FFFE,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             pc_src,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      instr_in,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus8,
    output logic [31:0]      instr_out,
    output logic             valid,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0]       target_aligned;
    logic [31:0]       pc_plus4;
    logic              cnt_full;
    logic              is_halt;

    assign target_aligned = {branch_target[31:2], 2'b00};
    assign pc_plus4       = pc_q + 32'd4;
    assign cnt_full       = &cnt_q;
    // Branch-to-self with the halt encoding; any other target is an ordinary branch.
    assign is_halt        = (instr_in == HALT_INSTR) && pc_src && (target_aligned == pc_q);

    // State, PC and retire counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, next-PC and output decode.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        valid     = 1'b0;
        halted    = 1'b0;
        instr_out = 32'h0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                valid     = 1'b1;
                instr_out = instr_in;
                if (!stall) begin
                    if (!cnt_full) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (is_halt) begin
                        // Halt instruction retires but the PC stays on it.
                        state_d = StHalt;
                    end else if (pc_src) begin
                        pc_d = target_aligned;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign pc          = pc_q;
    assign pc_plus8    = pc_q + 32'd8;
    assign retired_cnt = cnt_q;

endmodule
